imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised successor to the decode-stage 16→32 sign extender.
- Extracts the immediate from a 32-bit RISC-V instruction for a selected format (I/S/B/U/J) and sign-extends it to XLEN.
- Registered valid/ready pipeline stage with a 2-entry skid buffer, sitting between the decode and execute stages.
- Gives full throughput with registered ready, so no combinational ready path crosses the stage.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 5, width of the sideband tag carried alongside each immediate (for example rd index); must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all buffered entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- in_instr  in  32  raw instruction word.
- in_fmt  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (optional), 110/111 illegal.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  in_fmt of the entry.
- out_tag  out  TAG_W  in_tag of the entry.
- out_illegal  out  1  format code not supported.

Behaviour:
- Extraction, combinational on the input side, with sext to XLEN from the MSB shown:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25],instr[11:7]}).
  - B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - U: sext({instr[31:12],12'b0}); with XLEN=64, bits 63:32 copy instr[31].
  - J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - Illegal code: imm = 0, illegal = 1. Legal code: illegal = 0.
- Storage: 2 entries, main output register plus skid register, each holding {imm, fmt, tag, illegal}.
- Latency: accepted entry appears on out_* exactly 1 cycle after the in_valid && in_ready edge.
- Throughput: one entry per cycle while out_ready = 1.
- Handshake:
  - Input transfer happens when in_valid && in_ready; output transfer when out_valid && out_ready.
  - out_* are stable while out_valid && !out_ready.
  - out_valid never drops without a transfer, except on rst or flush.
- in_ready is a registered flop. It equals 1 when the skid register is empty.
- FSM states: EMPTY, ONE (output register only), TWO (output + skid).
  - EMPTY, input transfer → ONE.
  - ONE, input transfer and no output transfer → TWO. The new entry goes to skid and in_ready goes low next cycle.
  - ONE, input transfer and output transfer → ONE. The output register reloads with the new entry.
  - ONE, output transfer only → EMPTY.
  - TWO, output transfer → ONE. Skid moves to the output register and in_ready rises next cycle.
  - TWO never sees an input transfer, because in_ready = 0.
- Ordering: strictly FIFO; tag order at the output equals acceptance order.
- Reset (rst = 1 at a clock edge):
  - State EMPTY; out_valid = 0, in_ready = 1.
  - out_imm = 0, out_fmt = 0, out_tag = 0, out_illegal = 0.
  - Reset mid-transfer discards all entries. An in_valid presented in the reset cycle is not accepted.
- Flush: same effect as rst on valid, state and ready. Data registers may hold their values. rst has priority over flush.
- Data registers load only on their own enable, so there is no X-propagation from an idle input.

Optional Feature:
- Macro: IMMGEN_ZIMM_EN.
- Defined: fmt 101 (Z, CSR zimm) yields zero-extended {XLEN-5 zeros, instr[19:15]} with illegal = 0.
- Not defined: fmt 101 is illegal (imm = 0, illegal = 1).
- Port list is identical in both builds.

Test Plan:
- I format, XLEN=32: in_instr 0xFFF00093, fmt 000, tag 3 → next cycle out_imm 0xFFFFFFFF, out_tag 3, out_illegal 0.
- S and B formats: 0xFE112E23 with fmt 001 → 0xFFFFFFFC. Then 0xFE000EE3 with fmt 010 → 0xFFFFFFFC. Both back-to-back with out_ready = 1, one result per cycle, in order.
- U format, XLEN=64: 0x80000037 with fmt 011 → out_imm 0xFFFFFFFF80000000. 0x12345037 → 0x0000000012345000.
- Backpressure: hold out_ready = 0 and stream tags 1, 2, 3.
  - Tags 1 and 2 are accepted; in_ready falls the cycle after tag 2 is accepted.
  - out_* hold tag 1 stable.
  - Release out_ready: outputs tags 1, 2, 3 in consecutive cycles with no loss or duplication.
- Illegal/optional format:
  - fmt 110 → out_imm 0, out_illegal 1.
  - fmt 101 on 0x000FD073 → with IMMGEN_ZIMM_EN, out_imm 0x0000001F, illegal 0; without it, out_imm 0, illegal 1.
- Reset/flush mid-operation: fill to TWO, assert flush for one cycle → next cycle out_valid 0, in_ready 1. Repeat with rst → all out_* equal 0. The first entry after release emerges with 1-cycle latency.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate extractor (I/S/B/U/J) behind a registered-ready valid/ready stage with a skid entry.
// Optional: define IMMGEN_ZIMM_EN to decode fmt 101 as the zero-extended CSR zimm field.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_fmt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } ent_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t             state, state_nx;
  ent_t               new_e, out_q, skid_q;
  logic signed [31:0] imm32;
  logic               ill;
  logic               in_xfer, out_xfer;
  logic               ld_out, ld_skid, mv_skid;

  // Every format fits in 32 bits, so build a signed 32-bit value and widen once.
  always_comb begin
    imm32 = '0;
    ill   = 1'b0;
    case (in_fmt)
      3'b000: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      3'b001: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      3'b010: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
      3'b011: imm32 = {in_instr[31:12], 12'b0};
      3'b100: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
`ifdef IMMGEN_ZIMM_EN
      3'b101: imm32 = {27'b0, in_instr[19:15]};
`else
      3'b101: ill = 1'b1;
`endif
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    new_e     = '0;
    new_e.imm = XLEN'(imm32);
    new_e.fmt = in_fmt;
    new_e.tag = in_tag;
    new_e.ill = ill;
  end

  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_nx = state;
    ld_out   = 1'b0;
    ld_skid  = 1'b0;
    mv_skid  = 1'b0;
    case (state)
      EMPTY: if (in_xfer) begin
        state_nx = ONE;
        ld_out   = 1'b1;
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          ld_out = 1'b1;
        end else if (in_xfer) begin
          state_nx = TWO;
          ld_skid  = 1'b1;
        end else if (out_xfer) begin
          state_nx = EMPTY;
        end
      end
      TWO: if (out_xfer) begin
        state_nx = ONE;
        mv_skid  = 1'b1;
      end
      default: state_nx = EMPTY;
    endcase
  end

  // in_ready is precomputed from the next state so it leaves the stage straight from a flop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx != TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      if (ld_out)       out_q <= new_e;
      else if (mv_skid) out_q <= skid_q;
      if (ld_skid)      skid_q <= new_e;
    end
  end

  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_tag     = out_q.tag;
  assign out_illegal = out_q.ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances on shared inputs, checked against a queue model.
module tb_imm_gen_pipe;

  logic        clk, rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [2:0]  in_fmt;
  logic [4:0]  in_tag;

  logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
  logic [4:0]  tag32, tag64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_fmt(in_fmt), .in_tag(in_tag), .out_valid(vld32),
    .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32), .out_tag(tag32),
    .out_illegal(ill32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_fmt(in_fmt), .in_tag(in_tag), .out_valid(vld64),
    .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64), .out_tag(tag64),
    .out_illegal(ill64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [4:0]  tag;
    logic        ill;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   passes = 0;

  logic        ob_valid, ob_ready, ob_valid64, ob_ready64, ob_ill, ob_ill64;
  logic [31:0] ob_imm;
  logic [63:0] ob_imm64;
  logic [2:0]  ob_fmt, ob_fmt64;
  logic [4:0]  ob_tag, ob_tag64;
  logic        ex_valid, ex_ready, acc;
  ent_t        ex_e;

  // Reference: immediates assembled arithmetically from field values.
  function automatic ent_t mk(input logic [31:0] ins, input logic [2:0] f, input logic [4:0] t);
    ent_t e;
    logic signed [63:0] s, a;
    s = 64'(signed'(ins));
    e.fmt = f; e.tag = t; e.ill = 1'b0; e.imm = '0;
    case (f)
      3'd0: e.imm = s >>> 20;
      3'd1: begin a = s >>> 25; e.imm = a * 32 + 64'((ins >> 7) & 32'h1f); end
      3'd2: begin
        a = s >>> 31;
        e.imm = a * 4096 + 64'(ins[7]) * 2048 + 64'((ins >> 25) & 32'h3f) * 32
              + 64'((ins >> 8) & 32'hf) * 2;
      end
      3'd3: e.imm = s & ~64'hfff;
      3'd4: begin
        a = s >>> 31;
        e.imm = a * 1048576 + 64'((ins >> 12) & 32'hff) * 4096
              + 64'((ins >> 20) & 32'h1) * 2048 + 64'((ins >> 21) & 32'h3ff) * 2;
      end
`ifdef IMMGEN_ZIMM_EN
      3'd5: e.imm = 64'((ins >> 15) & 32'h1f);
`else
      3'd5: e.ill = 1'b1;
`endif
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Sample at the falling edge, advance the model, then move past the rising edge.
  task automatic step();
    @(negedge clk);
    ob_valid = vld32; ob_ready = rdy32; ob_imm = imm32; ob_fmt = fmt32; ob_tag = tag32; ob_ill = ill32;
    ob_valid64 = vld64; ob_ready64 = rdy64; ob_imm64 = imm64; ob_fmt64 = fmt64;
    ob_tag64 = tag64; ob_ill64 = ill64;
    ex_valid = (q.size() != 0);
    ex_ready = (q.size() < 2);
    ex_e = ex_valid ? q[0] : '{imm: '0, fmt: '0, tag: '0, ill: 1'b0};
    acc = 1'b0;
    if (rst || flush) begin
      q.delete();
    end else begin
      if (ex_valid && out_ready) void'(q.pop_front());
      if (in_valid && ex_ready) begin
        q.push_back(mk(in_instr, in_fmt, in_tag));
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] f, input logic [4:0] t);
    in_valid = v; in_instr = ins; in_fmt = f; in_tag = t;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 32'hfff00093, 3'd0, 5'd7);
    step(); step();
    rst = 1'b0; in_valid = 1'b0;
    step();
    checks++;
    if (ob_valid !== 1'b0 || ob_ready !== 1'b1 || ob_valid64 !== 1'b0 || ob_ready64 !== 1'b1)
      $display("FAIL reset_hs: valid=%b ready=%b valid64=%b ready64=%b, want 0 1 0 1",
               ob_valid, ob_ready, ob_valid64, ob_ready64);
    else passes++;
    checks++;
    if ({ob_imm, ob_fmt, ob_tag, ob_ill, ob_imm64, ob_fmt64, ob_tag64, ob_ill64} !== '0)
      $display("FAIL reset_data: imm=%h fmt=%0d tag=%0d ill=%b imm64=%h, want all 0",
               ob_imm, ob_fmt, ob_tag, ob_ill, ob_imm64);
    else passes++;
  endtask

  task automatic test_i_fmt();
    out_ready = 1'b1;
    drive(1'b1, 32'hfff00093, 3'd0, 5'd3);
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (ob_valid !== 1'b1 || ob_imm !== 32'hffffffff || ob_tag !== 5'd3 || ob_ill !== 1'b0
        || ob_imm64 !== 64'hffffffffffffffff)
      $display("FAIL i_fmt: valid=%b imm=%h tag=%0d ill=%b imm64=%h, want 1 ffffffff 3 0 ffffffffffffffff",
               ob_valid, ob_imm, ob_tag, ob_ill, ob_imm64);
    else passes++;
    step();
    checks++;
    if (ob_valid !== 1'b0) $display("FAIL i_fmt_drain: valid=%b, want 0", ob_valid);
    else passes++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(1'b1, 32'hfe112e23, 3'd1, 5'd4);
    step();
    drive(1'b1, 32'hfe000ee3, 3'd2, 5'd5);
    step();
    checks++;
    if (ob_valid !== 1'b1 || ob_imm !== 32'hfffffffc || ob_tag !== 5'd4 || ob_ready !== 1'b1)
      $display("FAIL s_fmt: valid=%b imm=%h tag=%0d ready=%b, want 1 fffffffc 4 1",
               ob_valid, ob_imm, ob_tag, ob_ready);
    else passes++;
    in_valid = 1'b0;
    step();
    checks++;
    if (ob_valid !== 1'b1 || ob_imm !== 32'hfffffffc || ob_tag !== 5'd5 || ob_fmt !== 3'd2)
      $display("FAIL b_fmt: valid=%b imm=%h tag=%0d fmt=%0d, want 1 fffffffc 5 2",
               ob_valid, ob_imm, ob_tag, ob_fmt);
    else passes++;
    step();
  endtask

  task automatic test_u_fmt();
    out_ready = 1'b1;
    drive(1'b1, 32'h80000037, 3'd3, 5'd8);
    step();
    drive(1'b1, 32'h12345037, 3'd3, 5'd9);
    step();
    checks++;
    if (ob_imm64 !== 64'hffffffff80000000 || ob_imm !== 32'h80000000 || ob_tag64 !== 5'd8)
      $display("FAIL u_neg: imm64=%h imm=%h tag=%0d, want ffffffff80000000 80000000 8",
               ob_imm64, ob_imm, ob_tag64);
    else passes++;
    in_valid = 1'b0;
    step();
    checks++;
    if (ob_imm64 !== 64'h0000000012345000 || ob_imm !== 32'h12345000 || ob_ill64 !== 1'b0)
      $display("FAIL u_pos: imm64=%h imm=%h ill=%b, want 0000000012345000 12345000 0",
               ob_imm64, ob_imm, ob_ill64);
    else passes++;
    step();
  endtask

  task automatic test_backpressure();
    logic [4:0] want_tag [8];
    logic       want_rdy [8];
    logic [4:0] nxt;
    want_tag = '{5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd2, 5'd3, 5'd0};
    want_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    out_ready = 1'b0;
    nxt = 5'd1;
    drive(1'b1, $urandom, 3'($urandom_range(0, 4)), nxt);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) out_ready = 1'b1;
      step();
      if (i >= 2) begin
        checks++;
        if (ob_valid !== (i < 7) || ob_ready !== want_rdy[i] || (i < 7 && ob_tag !== want_tag[i]))
          $display("FAIL bp_cycle%0d: valid=%b ready=%b tag=%0d, want %b %b %0d",
                   i, ob_valid, ob_ready, ob_tag, (i < 7), want_rdy[i], want_tag[i]);
        else passes++;
        checks++;
        if (ex_valid && {ob_imm64, ob_fmt, ob_ill} !== {ex_e.imm, ex_e.fmt, ex_e.ill})
          $display("FAIL bp_data%0d: imm=%h fmt=%0d ill=%b, want %h %0d %b",
                   i, ob_imm64, ob_fmt, ob_ill, ex_e.imm, ex_e.fmt, ex_e.ill);
        else passes++;
      end
      if (acc) begin
        nxt = nxt + 5'd1;
        if (nxt == 5'd4) in_valid = 1'b0;
        else drive(1'b1, $urandom, 3'($urandom_range(0, 4)), nxt);
      end
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(1'b1, 32'hffffffff, 3'd6, 5'd10);
    step();
    drive(1'b1, 32'h000fd073, 3'd5, 5'd11);
    step();
    checks++;
    if (ob_imm !== 32'h0 || ob_ill !== 1'b1 || ob_imm64 !== 64'h0 || ob_ill64 !== 1'b1)
      $display("FAIL illegal_110: imm=%h ill=%b imm64=%h ill64=%b, want 0 1 0 1",
               ob_imm, ob_ill, ob_imm64, ob_ill64);
    else passes++;
    drive(1'b1, 32'h12345678, 3'd7, 5'd12);
    step();
`ifdef IMMGEN_ZIMM_EN
    checks++;
    if (ob_imm !== 32'h1f || ob_ill !== 1'b0 || ob_imm64 !== 64'h1f)
      $display("FAIL zimm: imm=%h ill=%b imm64=%h, want 1f 0 1f", ob_imm, ob_ill, ob_imm64);
    else passes++;
`else
    checks++;
    if (ob_imm !== 32'h0 || ob_ill !== 1'b1 || ob_imm64 !== 64'h0)
      $display("FAIL zimm_off: imm=%h ill=%b imm64=%h, want 0 1 0", ob_imm, ob_ill, ob_imm64);
    else passes++;
`endif
    in_valid = 1'b0;
    step();
    checks++;
    if (ob_imm !== 32'h0 || ob_ill !== 1'b1 || ob_tag !== 5'd12)
      $display("FAIL illegal_111: imm=%h ill=%b tag=%0d, want 0 1 12", ob_imm, ob_ill, ob_tag);
    else passes++;
    step();
  endtask

  task automatic test_flush_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'hfff00093, 3'd0, 5'd20); step();
    drive(1'b1, 32'h00100093, 3'd0, 5'd21); step();
    in_valid = 1'b0; flush = 1'b1;
    step();
    checks++;
    if (ob_valid !== 1'b1 || ob_ready !== 1'b0)
      $display("FAIL fill_two: valid=%b ready=%b, want 1 0", ob_valid, ob_ready);
    else passes++;
    flush = 1'b0;
    step();
    checks++;
    if (ob_valid !== 1'b0 || ob_ready !== 1'b1 || ob_valid64 !== 1'b0)
      $display("FAIL flush: valid=%b ready=%b valid64=%b, want 0 1 0", ob_valid, ob_ready, ob_valid64);
    else passes++;
    drive(1'b1, 32'h80000037, 3'd3, 5'd22); step();
    drive(1'b1, 32'hfe112e23, 3'd1, 5'd23); step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    checks++;
    if (ob_valid !== 1'b0 || ob_ready !== 1'b1 || {ob_imm, ob_fmt, ob_tag, ob_ill, ob_imm64} !== '0)
      $display("FAIL rst_mid: valid=%b ready=%b imm=%h fmt=%0d tag=%0d ill=%b, want 0 1 0 0 0 0",
               ob_valid, ob_ready, ob_imm, ob_fmt, ob_tag, ob_ill);
    else passes++;
    out_ready = 1'b1;
    drive(1'b1, 32'h000fd073, 3'd4, 5'd24); step();
    in_valid = 1'b0;
    step();
    checks++;
    if (ob_valid !== 1'b1 || ob_tag !== 5'd24 || ob_imm64 !== ex_e.imm)
      $display("FAIL post_rst_latency: valid=%b tag=%0d imm64=%h, want 1 24 %h",
               ob_valid, ob_tag, ob_imm64, ex_e.imm);
    else passes++;
    step();
  endtask

  task automatic test_random();
    int hs_bad, data_bad;
    hs_bad = 0; data_bad = 0;
    for (int i = 0; i < 400; i++) begin
      flush = ($urandom_range(0, 49) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      drive(($urandom_range(0, 9) < 7), $urandom, 3'($urandom_range(0, 7)), 5'($urandom));
      step();
      checks++;
      if (ob_valid !== ex_valid || ob_ready !== ex_ready || ob_valid64 !== ex_valid
          || ob_ready64 !== ex_ready) begin
        if (hs_bad < 5)
          $display("FAIL rand_hs%0d: valid=%b ready=%b, want %b %b", i, ob_valid, ob_ready, ex_valid, ex_ready);
        hs_bad++;
      end else passes++;
      if (ex_valid) begin
        checks++;
        if ({ob_imm, ob_fmt, ob_tag, ob_ill} !== {ex_e.imm[31:0], ex_e.fmt, ex_e.tag, ex_e.ill}
            || {ob_imm64, ob_fmt64, ob_tag64, ob_ill64} !== {ex_e.imm, ex_e.fmt, ex_e.tag, ex_e.ill}) begin
          if (data_bad < 5)
            $display("FAIL rand_data%0d: imm64=%h fmt=%0d tag=%0d ill=%b, want %h %0d %0d %b",
                     i, ob_imm64, ob_fmt, ob_tag, ob_ill, ex_e.imm, ex_e.fmt, ex_e.tag, ex_e.ill);
          data_bad++;
        end else passes++;
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_fmt = '0; in_tag = '0;
    test_reset();
    test_i_fmt();
    test_back_to_back();
    test_u_fmt();
    test_backpressure();
    test_illegal();
    test_flush_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
